// File: rtl/pong_screen_sequencer.sv
// Screen/mode sequencer for the Pong console: title, serve countdown, play, game over.
// Every output is registered from next-state values, so each one reacts in the cycle after its cause.
module pong_screen_sequencer #(
    parameter int BLINK_FRAMES  = 30,
    parameter int COUNT_FRAMES  = 60,
    parameter int WIN_SCORE     = 7,
    parameter int GAMEOVER_HOLD = 120,
    parameter int CNT_W         = 9
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       key_press,
    input  logic       point_scored,
    input  logic [3:0] score_l,
    input  logic [3:0] score_r,
    output logic       title_en,
    output logic       prompt_en,
    output logic       countdown_en,
    output logic [1:0] countdown_digit,
    output logic       game_run,
    output logic       gameover_en,
    output logic       winner,
    output logic       score_clr
);

    localparam logic [1:0] S_TITLE = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(COUNT_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_VAL   = CNT_W'(GAMEOVER_HOLD);
    localparam logic [3:0]       WIN_VAL    = 4'(WIN_SCORE);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_bcnt;
    logic             r_phase;
    logic [1:0]       r_digit;

    logic [1:0]       w_nxt_state;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [CNT_W-1:0] w_nxt_bcnt;
    logic             w_nxt_phase;
    logic [1:0]       w_nxt_digit;
    logic             w_nxt_winner;
    logic             w_nxt_prompt;
    logic             w_clr;
    logic             w_l_win;
    logic             w_r_win;

    assign w_l_win = (score_l >= WIN_VAL);
    assign w_r_win = (score_r >= WIN_VAL);

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_cnt    = r_cnt;
        w_nxt_bcnt   = r_bcnt;
        w_nxt_phase  = r_phase;
        w_nxt_digit  = r_digit;
        w_nxt_winner = winner;
        w_clr        = 1'b0;
        case (r_state)
            S_TITLE: begin
                // A key press on a tick cycle takes priority; the blink toggle is dropped
                if (key_press) begin
                    w_nxt_state = S_COUNT;
                    w_nxt_cnt   = CNT_ZERO;
                    w_nxt_digit = 2'd3;
                    w_nxt_phase = 1'b1;
                    w_clr       = 1'b1;
                end else if (frame_tick) begin
                    if (r_cnt == BLINK_LAST) begin
                        w_nxt_cnt   = CNT_ZERO;
                        w_nxt_phase = ~r_phase;
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_ONE;
                    end
                end
            end
            S_COUNT: begin
                if (frame_tick) begin
                    if (r_cnt == COUNT_LAST) begin
                        w_nxt_cnt = CNT_ZERO;
                        if (r_digit > 2'd1) begin
                            w_nxt_digit = r_digit - 2'd1;
                        end else begin
                            w_nxt_state = S_PLAY;
                            w_nxt_digit = 2'd0;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + CNT_ONE;
                    end
                end
            end
            S_PLAY: begin
                if (point_scored) begin
                    w_nxt_cnt = CNT_ZERO;
                    if (w_l_win || w_r_win) begin
                        w_nxt_state  = S_OVER;
                        w_nxt_winner = w_r_win;
                        w_nxt_phase  = 1'b1;
                        w_nxt_bcnt   = CNT_ZERO;
                    end else begin
                        w_nxt_state = S_COUNT;
                        w_nxt_digit = 2'd3;
                    end
                end
            end
            default: begin
                // The hold counter parks at its terminal value; a separate counter paces the blink afterwards
                if (r_cnt == HOLD_VAL) begin
                    if (key_press) begin
                        w_nxt_state = S_TITLE;
                        w_nxt_cnt   = CNT_ZERO;
                        w_nxt_bcnt  = CNT_ZERO;
                        w_nxt_phase = 1'b1;
                    end else if (frame_tick) begin
                        if (r_bcnt == BLINK_LAST) begin
                            w_nxt_bcnt  = CNT_ZERO;
                            w_nxt_phase = ~r_phase;
                        end else begin
                            w_nxt_bcnt = r_bcnt + CNT_ONE;
                        end
                    end
                end else if (frame_tick) begin
                    w_nxt_cnt = r_cnt + CNT_ONE;
                end
            end
        endcase
    end

    always_comb begin
        w_nxt_prompt = 1'b0;
        if (w_nxt_state == S_TITLE) begin
            w_nxt_prompt = w_nxt_phase;
        end else if ((w_nxt_state == S_OVER) && (w_nxt_cnt == HOLD_VAL)) begin
            w_nxt_prompt = w_nxt_phase;
        end
    end

    always_ff @(posedge clk_0) begin
        if (rst) begin
            r_state         <= S_TITLE;
            r_cnt           <= CNT_ZERO;
            r_bcnt          <= CNT_ZERO;
            r_phase         <= 1'b1;
            r_digit         <= 2'd0;
            title_en        <= 1'b1;
            prompt_en       <= 1'b1;
            countdown_en    <= 1'b0;
            countdown_digit <= 2'd0;
            game_run        <= 1'b0;
            gameover_en     <= 1'b0;
            winner          <= 1'b0;
            score_clr       <= 1'b0;
        end else begin
            r_state         <= w_nxt_state;
            r_cnt           <= w_nxt_cnt;
            r_bcnt          <= w_nxt_bcnt;
            r_phase         <= w_nxt_phase;
            r_digit         <= w_nxt_digit;
            title_en        <= (w_nxt_state == S_TITLE);
            prompt_en       <= w_nxt_prompt;
            countdown_en    <= (w_nxt_state == S_COUNT);
            countdown_digit <= (w_nxt_state == S_COUNT) ? w_nxt_digit : 2'd0;
            game_run        <= (w_nxt_state == S_PLAY);
            gameover_en     <= (w_nxt_state == S_OVER);
            winner          <= w_nxt_winner;
            score_clr       <= w_clr;
        end
    end

endmodule

// File: doc/pong_screen_sequencer.md
Name: pong_screen_sequencer

Overview:
Top-level screen/mode controller for the Pong console. It sequences the title screen, the 3-2-1 serve countdown, live play and the game-over screen. It drives enable/select signals into the text overlay blocks (title/prompt, countdown digit, game-over banner) and a run enable into the ball/paddle logic. All timing is counted in video frames using a one-cycle frame tick from the VGA timing block.

Parameters:
BLINK_FRAMES, 30, frames per prompt blink half-period (prompt on 30, off 30)
COUNT_FRAMES, 60, frames each countdown digit is displayed
WIN_SCORE, 7, score that ends the game (4-bit compare)
GAMEOVER_HOLD, 120, frames after entering GAME_OVER before a key press is accepted
CNT_W, 9, frame counter width; must hold max(BLINK_FRAMES, COUNT_FRAMES, GAMEOVER_HOLD)

Ports:
clk_0  input  1  pixel clock; sole clock
rst  input  1  synchronous active-high reset
frame_tick  input  1  one-cycle pulse per frame (start of vertical blank)
key_press  input  1  one-cycle pulse, any key pressed (already debounced/edge-detected)
point_scored  input  1  one-cycle pulse when a point is awarded; scores below already updated that cycle
score_l  input  4  left player score
score_r  input  4  right player score
title_en  output  1  show "PONG" title
prompt_en  output  1  show "Press any key to start" (blink-gated)
countdown_en  output  1  show countdown digit
countdown_digit  output  2  digit to show: 3, 2 or 1
game_run  output  1  ball/paddle motion enable
gameover_en  output  1  show game-over banner
winner  output  1  0 = left won, 1 = right won; valid while gameover_en=1
score_clr  output  1  one-cycle pulse clearing both scores

Behaviour:
- Clock clk_0 only; reset synchronous, active-high. All outputs are registered. Each output changes on the clock edge at which its causing input is sampled, so it is visible in the cycle after that input.
- Reset values: state TITLE, frame counter 0, blink phase 1. Outputs: title_en=1, prompt_en=1, winner=0; all other outputs 0.
- A frame counter (CNT_W bits) counts frame_tick pulses only. It clears on every state transition and never wraps past its terminal value.
- TITLE:
  - title_en=1; prompt_en=blink phase.
  - When the counter is at BLINK_FRAMES-1 and frame_tick arrives: counter returns to 0 and the phase toggles.
  - key_press: go to COUNTDOWN with digit=3, pulse score_clr for exactly 1 cycle, and set phase to 1 for the next TITLE entry.
  - If key_press and frame_tick coincide, key_press wins and the blink toggle is discarded.
- COUNTDOWN:
  - countdown_en=1; countdown_digit is held.
  - When the counter is at COUNT_FRAMES-1 and frame_tick arrives: counter goes to 0; if digit>1, decrement the digit, else go to PLAY.
  - key_press and point_scored are ignored.
- PLAY:
  - game_run=1.
  - point_scored with score_l>=WIN_SCORE or score_r>=WIN_SCORE: go to GAME_OVER. winner=1 if score_r>=WIN_SCORE, else 0 (if both are at or above WIN_SCORE, right wins).
  - point_scored otherwise: go to COUNTDOWN with digit=3; scores are not cleared.
  - game_run drops in the cycle after the point_scored pulse.
- GAME_OVER:
  - gameover_en=1; prompt_en=0 until the hold expires.
  - The counter saturates at GAMEOVER_HOLD.
  - Once the counter equals GAMEOVER_HOLD: prompt_en follows the blink phase (same blink rule as TITLE), and key_press goes to TITLE.
  - key_press before the hold expires is ignored.
- On entry to TITLE: title_en=1, prompt_en=1; score_clr is not pulsed (scores are cleared when the next game starts).
- Output enables are one-hot across title_en, countdown_en, game_run and gameover_en; exactly one is high in every cycle.
- point_scored outside PLAY is ignored. key_press outside TITLE/GAME_OVER is ignored.
- rst asserted in any state: the next cycle shows the reset values; any pending countdown or hold is abandoned.

Test Plan:
1. Reset, then hold rst low with no key for 60 frame_ticks -> title_en=1 throughout; prompt_en=1 for ticks 1-30, 0 for ticks 31-60, 1 after tick 60.
2. In TITLE, key_press coincident with a frame_tick -> next cycle countdown_en=1, digit=3, score_clr=1 for one cycle; digit becomes 2 after 60 ticks and 1 after 120; at tick 180 game_run=1 and countdown_en=0.
3. In PLAY, point_scored with score_l=3, score_r=2 -> COUNTDOWN with digit=3, score_clr stays 0; key_press during the countdown has no effect.
4. In PLAY, point_scored with score_r=7 -> gameover_en=1, winner=1, game_run=0 the next cycle; key_press at tick 50 ignored; prompt_en=0 until tick 120; key_press after tick 120 -> title_en=1, prompt_en=1.
5. Assert rst mid-COUNTDOWN (digit=2) -> next cycle title_en=1, countdown_en=0, digit register 0; a fresh key_press restarts the countdown at 3.
6. Every cycle across all scenarios -> exactly one of title_en, countdown_en, game_run, gameover_en is high.
